// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM states, handshake levels, aluop codes.
package ex_div_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   typedef logic [63:0] double_reg_bus_t;

   typedef enum logic [7:0] {
      EXE_DIV_OP  = 8'b0001_1010,
      EXE_DIVU_OP = 8'b0001_1011
   } div_aluop_e;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU returning {remainder, quotient}; one bit per cycle.
// Optional macro DIV_ZERO_FLAG_EN adds a registered divide-by-zero flag output.
module ex_div
   import ex_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
`ifdef DIV_ZERO_FLAG_EN
   output logic               ready_o,
   output logic               div_zero_o
`else
   output logic               ready_o
`endif
);

   div_state_e       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
   logic             quo_neg, rem_neg;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] op1_mag, op2_mag, quo_final, rem_final;
   logic             last_step;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   assign op1_mag   = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
   assign op2_mag   = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
   // Extra MSB of the trial subtraction is the borrow: set means the divisor did not fit.
   assign trial     = {1'b0, rem_q[WIDTH-2:0], quo_q[WIDTH-1]} - {1'b0, dsr_q};
   assign last_step = (cnt == CNT_W'(WIDTH - 1));
   assign quo_final = quo_neg ? negate(quo_q) : quo_q;
   assign rem_final = rem_neg ? negate(rem_q) : rem_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) state <= DIV_FREE;
      else        state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         DIV_FREE:
            if (start_i == DIV_START && !annul_i)
               state_next = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
         DIV_BYZERO:
            state_next = annul_i ? DIV_FREE : DIV_END;
         DIV_ON:
            if (annul_i)        state_next = DIV_FREE;
            else if (last_step) state_next = DIV_END;
         DIV_END:
            if (start_i == DIV_STOP || annul_i) state_next = DIV_FREE;
         default:
            state_next = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dsr_q    <= '0;
         quo_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         ready_o  <= DIV_RESULT_NOT_READY;
         result_o <= '0;
      end else begin
         ready_o  <= DIV_RESULT_NOT_READY;
         result_o <= '0;
         case (state)
            DIV_FREE:
               if (state_next == DIV_ON) begin
                  cnt     <= '0;
                  rem_q   <= '0;
                  quo_q   <= op1_mag;
                  dsr_q   <= op2_mag;
                  quo_neg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  rem_neg <= signed_div_i & opdata1_i[WIDTH-1];
               end else if (state_next == DIV_BYZERO) begin
                  // Cleared registers make the common END path emit a zero result.
                  cnt     <= '0;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  quo_neg <= 1'b0;
                  rem_neg <= 1'b0;
               end
            DIV_ON:
               if (!annul_i) begin
                  if (!trial[WIDTH]) begin
                     rem_q <= trial[WIDTH-1:0];
                     quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                     quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + CNT_W'(1);
               end
            DIV_END:
               if (state_next == DIV_END) begin
                  ready_o  <= DIV_RESULT_READY;
                  result_o <= {rem_final, quo_final};
               end
            default: ;
         endcase
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   always_ff @(posedge clk) begin
      if (!reset) div_zero_o <= 1'b0;
      else        div_zero_o <= (state_next == DIV_BYZERO) || (div_zero_o && state_next == DIV_END);
   end
`endif

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, random operands against an arithmetic model,
// and hand-written annul/reset sequences.
module tb_ex_div;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        signed_div = 1'b0;
   logic        start = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [63:0] result;
   logic        ready;
`ifdef DIV_ZERO_FLAG_EN
   logic        div_zero;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_div #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
`ifdef DIV_ZERO_FLAG_EN
      .div_zero_o   (div_zero),
`endif
      .ready_o      (ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: 64-bit signed arithmetic cannot overflow for 32-bit operands; SV truncates toward zero.
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return 64'd0;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Called at the negedge where start is (or becomes) accepted on the following posedge.
   task automatic finish_div(input string name, input logic [31:0] b, input logic [63:0] exp);
      int lat;
      @(negedge clk);
      check({name, " ready right after accept"}, ready, 64'd0);
      op1 = $urandom;
      op2 = $urandom;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ready) begin
            lat = k;
            break;
         end
      end
      check({name, " latency"}, lat, (b == 0) ? 64'd2 : 64'd33);
      check({name, " result"}, result, exp);
`ifdef DIV_ZERO_FLAG_EN
      check({name, " div_zero"}, div_zero, (b == 0) ? 64'd1 : 64'd0);
`endif
      repeat (3) @(negedge clk);
      check({name, " ready held"}, ready, 64'd1);
      check({name, " result held"}, result, exp);
      start = 1'b0;
      @(negedge clk);
      check({name, " ready after stop"}, ready, 64'd0);
      check({name, " result after stop"}, result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
      check({name, " div_zero after stop"}, div_zero, 64'd0);
`endif
   endtask

   task automatic do_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
      @(negedge clk);
      signed_div = s;
      op1 = a;
      op2 = b;
      start = 1'b1;
      finish_div(name, b, exp);
   endtask

   typedef struct {
      string       name;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int bad;
      logic        rs;
      logic [31:0] ra, rb;

      vecs[0] = '{"divu 7/2",        1'b0, 32'd7,          32'd2,          64'h00000001_00000003};
      vecs[1] = '{"div -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
      vecs[2] = '{"div 7/-2",        1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
      vecs[3] = '{"div by zero",     1'b0, 32'h0000_1234,  32'd0,          64'h0};
      vecs[4] = '{"div overflow",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000};
      vecs[5] = '{"divu max/1",      1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};
      vecs[6] = '{"div signed by 0", 1'b1, 32'h8000_0001,  32'd0,          64'h0};

      repeat (3) @(negedge clk);
      check("reset ready", ready, 64'd0);
      check("reset result", result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
      check("reset div_zero", div_zero, 64'd0);
`endif
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         do_div(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = 32'($urandom_range(1, 300));
            3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: rb = $urandom;
         endcase
         do_div("random", rs, ra, rb, ref_div(rs, ra, rb));
      end

      // Annul mid-iteration: no result, then a fresh division is correct.
      @(negedge clk);
      signed_div = 1'b0;
      op1 = 32'h1234_5678;
      op2 = 32'h55;
      start = 1'b1;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      check("annul ready", ready, 64'd0);
      check("annul result", result, 64'd0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) bad++;
      end
      check("annul no late ready", bad, 64'd0);
      do_div("after annul 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

      // Annul while in the divide-by-zero state.
      @(negedge clk);
      op1 = 32'h1234;
      op2 = 32'd0;
      start = 1'b1;
      @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      check("byzero annul ready", ready, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
      check("byzero annul div_zero", div_zero, 64'd0);
`endif
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready) bad++;
      end
      check("byzero annul no ready", bad, 64'd0);

      // Reset mid-iteration, then held low with start asserted.
      @(negedge clk);
      signed_div = 1'b0;
      op1 = 32'd1000;
      op2 = 32'd3;
      start = 1'b1;
      repeat (20) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid reset ready", ready, 64'd0);
      check("mid reset result", result, 64'd0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) bad++;
      end
      check("reset blocks start", bad, 64'd0);
      op1 = 32'd1000;
      op2 = 32'd3;
      reset = 1'b1;
      finish_div("after reset 1000/3", 32'd3, 64'h00000001_0000014D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 divider for DIV/DIVU, owned by the EX stage.
- EX decodes `ex_aluop`/`ex_reg1`/`ex_reg2` from the ID/EX register and drives `start_i`.
- `ex_div` returns `{remainder, quotient}` for HI/LO.
- While a division is in flight, EX raises its stall request so the ID/EX register holds the instruction.

Parameters:
- WIDTH, 32, operand width (equals `RegBus` width).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk, low = reset.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; held high by EX until it has consumed the result.
- annul_i  input  1  flush; cancels any in-flight division.
- result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result_o valid.

Behaviour:
- States:
  - FREE: idle.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result held.
- Reset (reset=0 at posedge): state FREE, counter 0, ready_o=0, result_o=0, internal R/Q/sign registers 0. Reset overrides every state, including mid-iteration.
- FREE:
  - If start_i=1, annul_i=0 and opdata2_i=0: go to BYZERO.
  - If start_i=1, annul_i=0 and opdata2_i≠0: go to ON.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- Operand capture on the FREE→ON edge:
  - Signed and operand MSB=1: store the two's-complement magnitude.
  - Record quotient sign as opdata1_i[31]^opdata2_i[31], and remainder sign as opdata1_i[31]; both are recorded only for signed division.
  - R=0, Q=|dividend|, D=|divisor|, counter=0.
- ON, each cycle:
  - Form T = {R[30:0], Q[31]} − D, computed at 33 bits.
  - If T is non-negative: R←T[31:0], Q←{Q[30:0],1}.
  - Otherwise: R←{R[30:0],Q[31]}, Q←{Q[30:0],0}.
  - counter++.
  - When counter reaches 31 and that step completes (32 iterations total), go to END.
- END entry:
  - quotient = negate(Q) if the quotient sign is set, else Q.
  - remainder = negate(R) if the remainder sign is set, else R.
  - ready_o=1 and result_o holds the value.
- BYZERO: next cycle go to END with result_o=0, ready_o=1.
- END: hold ready_o=1 and result_o stable while start_i=1. When start_i=0, go to FREE next cycle with ready_o=0 and result_o=0.
- annul_i=1 in ON or BYZERO: go to FREE next cycle; ready_o=0, result_o=0, no result produced. annul_i in END behaves as start_i=0.
- Latency, with start accepted at edge N:
  - ready_o is high after edge N+33.
  - For divide-by-zero, ready_o is high after edge N+2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (magnitude wraps), remainder 0; no trap.
- Operand inputs are ignored outside FREE; EX may change them freely after acceptance.

Optional Feature:
- Macro: `DIV_ZERO_FLAG_EN`.
- When defined:
  - Adds output `div_zero_o` (1 bit), registered.
  - Set on the FREE→BYZERO transition; held through END; cleared on return to FREE, on annul and on reset.
  - EX may route it to exception logic.
- When undefined: port and logic absent; divide-by-zero behaviour is otherwise identical (result 0).

Decomposition:
- Add to defines.v:
  - State encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits).
  - `DivResultReady` / `DivResultNotReady`, `DivStart` / `DivStop`.
  - `DoubleRegBus` (63:0).
  - Aluop codes `EXE_DIV_OP` / `EXE_DIVU_OP`.
- No sub-module. The negate helper is a local function; one FSM always block plus one datapath block.

Test Plan:
- DIVU 7/2: start held → ready_o after 33 cycles, result_o = 0x00000001_00000003; start dropped → FREE next cycle with ready_o=0.
- DIV −7/2 (0xFFFFFFF9, 0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7/−2 → remainder 0x00000001, quotient 0xFFFFFFFD.
- Divide by zero (0x1234 / 0) → ready_o after 2 cycles, result_o = 0; with `DIV_ZERO_FLAG_EN`, div_zero_o=1 until start_i drops.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at iteration 10 → FREE next cycle, ready_o never asserts; a new start then gives a correct result for the new operands (100/7 → 0x00000002_0000000E).
- reset driven low at iteration 20 → next edge: state FREE, ready_o=0, result_o=0; reset driven low while start_i=1 → no division starts until reset returns high.
